// File: rtl/router_pkg.sv
// Shared header layout, packet type, error codes and FSM states for the
// router encapsulation/decapsulation paths.
package router_pkg;

   localparam int HDR_ID_LSB   = 0;
   localparam int HDR_ID_W     = 2;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_LEN_W    = 5;
   localparam int HDR_TYPE_LSB = 7;
   localparam int HDR_TYPE_W   = 2;
   localparam int HDR_ADDR_LSB = 9;
   localparam int HDR_ADDR_W   = 10;

   localparam logic [HDR_TYPE_W-1:0] PKT_TYPE_DATA = 2'b01;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_ID   = 2'd1;
   localparam logic [1:0] ERR_TYPE = 2'd2;
   localparam logic [1:0] ERR_LEN  = 2'd3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CHECK   = 3'd1,
      PAYLOAD = 3'd2,
      DROP    = 3'd3,
      DONE    = 3'd4
   } state_t;

   // First failing check wins: router ID, then packet type, then length.
   function automatic logic [1:0] hdr_err(input logic id_ok,
                                          input logic type_ok,
                                          input logic len_ok);
      logic [1:0] e;
      if (!id_ok) begin
         e = ERR_ID;
      end else if (!type_ok) begin
         e = ERR_TYPE;
      end else if (!len_ok) begin
         e = ERR_LEN;
      end else begin
         e = ERR_NONE;
      end
      return e;
   endfunction

endpackage

// File: rtl/router_hdr_decode.sv
// Combinational header decoder: splits a latched header word into its fields
// and classifies it against this router's ID.
module router_hdr_decode
   import router_pkg::*;
#(
   parameter int ADDR_WIDTH             = HDR_ADDR_W,
   parameter int NUMBER_PACKET          = 19,
   parameter int RECOGNIZE_ROUTER_WIDTH = HDR_ID_W,
   parameter int HDR_BITS               = HDR_ADDR_LSB + ADDR_WIDTH
) (
   input  logic [HDR_BITS-1:0]               hdr,
   input  logic [RECOGNIZE_ROUTER_WIDTH-1:0] my_router_id,
   output logic [HDR_LEN_W-1:0]              len,
   output logic [ADDR_WIDTH-1:0]             dst_addr,
   output logic                              len_zero,
   output logic [1:0]                        err
);

   localparam logic [HDR_LEN_W-1:0] MAX_LEN = HDR_LEN_W'(NUMBER_PACKET);

   logic [RECOGNIZE_ROUTER_WIDTH-1:0] dst_id_s;
   logic [HDR_TYPE_W-1:0]             type_s;
   logic                              id_ok_s;
   logic                              type_ok_s;
   logic                              len_ok_s;

   assign dst_id_s = hdr[HDR_ID_LSB +: RECOGNIZE_ROUTER_WIDTH];
   assign len      = hdr[HDR_LEN_LSB +: HDR_LEN_W];
   assign type_s   = hdr[HDR_TYPE_LSB +: HDR_TYPE_W];
   assign dst_addr = hdr[HDR_ADDR_LSB +: ADDR_WIDTH];

   assign id_ok_s   = (dst_id_s == my_router_id);
   assign type_ok_s = (type_s == PKT_TYPE_DATA);
   assign len_ok_s  = (len <= MAX_LEN);
   assign len_zero  = (len == {HDR_LEN_W{1'b0}});

   // Prioritised header classification.
   always_comb begin
      err = hdr_err(id_ok_s, type_ok_s, len_ok_s);
   end

endmodule

// File: rtl/router_packet_decap.sv
// Receive-side decapsulation: pops a header and a payload burst from a
// first-word-fall-through FIFO and writes the payload into local memory.
module router_packet_decap
   import router_pkg::*;
#(
   parameter int AURORA_DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH             = 10,
   parameter int NUMBER_PACKET          = 19,
   parameter int RECOGNIZE_ROUTER_WIDTH = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [RECOGNIZE_ROUTER_WIDTH-1:0] my_router_id,
   input  logic                              empty_in,
   input  logic [AURORA_DATA_WIDTH-1:0]      data_in,
   output logic                              rd_in,
   output logic                              mem_we,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   output logic [AURORA_DATA_WIDTH-1:0]      mem_wdata,
   input  logic                              mem_ready,
   output logic                              busy,
   output logic                              recv_done,
   output logic                              recv_err,
   output logic [1:0]                        err_code
);

   localparam int HDR_BITS = HDR_ADDR_LSB + ADDR_WIDTH;

   state_t                  state_r;
   state_t                  state_s;
   logic [HDR_BITS-1:0]     hdr_r;
   logic                    hdr_load_s;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [ADDR_WIDTH-1:0]   addr_s;
   logic [HDR_LEN_W-1:0]    remain_r;
   logic [HDR_LEN_W-1:0]    remain_s;
   logic [1:0]              err_r;
   logic [1:0]              err_s;

   logic [HDR_LEN_W-1:0]    dec_len_s;
   logic [ADDR_WIDTH-1:0]   dec_addr_s;
   logic                    dec_len_zero_s;
   logic [1:0]              dec_err_s;

   router_hdr_decode #(
      .ADDR_WIDTH             (ADDR_WIDTH),
      .NUMBER_PACKET          (NUMBER_PACKET),
      .RECOGNIZE_ROUTER_WIDTH (RECOGNIZE_ROUTER_WIDTH),
      .HDR_BITS               (HDR_BITS)
   ) u_hdr_decode (
      .hdr          (hdr_r),
      .my_router_id (my_router_id),
      .len          (dec_len_s),
      .dst_addr     (dec_addr_s),
      .len_zero     (dec_len_zero_s),
      .err          (dec_err_s)
   );

   assign mem_addr = addr_r;
   assign err_code = err_r;

   // Next-state, counters and FIFO/memory handshake.
   always_comb begin
      state_s    = state_r;
      addr_s     = addr_r;
      remain_s   = remain_r;
      err_s      = err_r;
      hdr_load_s = 1'b0;
      rd_in      = 1'b0;
      mem_we     = 1'b0;
      mem_wdata  = {AURORA_DATA_WIDTH{1'b0}};
      busy       = 1'b1;
      recv_done  = 1'b0;
      recv_err   = 1'b0;

      case (state_r)
         IDLE: begin
            // Gated by rst_n so nothing is popped while reset is held.
            if (rst_n && !empty_in) begin
               rd_in      = 1'b1;
               hdr_load_s = 1'b1;
               err_s      = ERR_NONE;
               state_s    = CHECK;
            end else begin
               busy    = 1'b0;
               state_s = IDLE;
            end
         end
         CHECK: begin
            err_s    = dec_err_s;
            remain_s = dec_len_s;
            if (dec_len_zero_s) begin
               state_s = DONE;
            end else if (dec_err_s != ERR_NONE) begin
               state_s = DROP;
            end else begin
               addr_s  = dec_addr_s;
               state_s = PAYLOAD;
            end
         end
         PAYLOAD: begin
            mem_we    = !empty_in;
            mem_wdata = data_in;
            if (!empty_in && mem_ready) begin
               rd_in    = 1'b1;
               addr_s   = addr_r + ADDR_WIDTH'(1);
               remain_s = remain_r - HDR_LEN_W'(1);
               if (remain_r == HDR_LEN_W'(1)) begin
                  state_s = DONE;
               end else begin
                  state_s = PAYLOAD;
               end
            end else begin
               state_s = PAYLOAD;
            end
         end
         DROP: begin
            if (!empty_in) begin
               rd_in    = 1'b1;
               remain_s = remain_r - HDR_LEN_W'(1);
               if (remain_r == HDR_LEN_W'(1)) begin
                  state_s = DONE;
               end else begin
                  state_s = DROP;
               end
            end else begin
               state_s = DROP;
            end
         end
         DONE: begin
            recv_done = 1'b1;
            recv_err  = (err_r != ERR_NONE);
            state_s   = IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_s = IDLE;
         end
      endcase
   end

   // State, header, address, length and error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         hdr_r    <= {HDR_BITS{1'b0}};
         addr_r   <= {ADDR_WIDTH{1'b0}};
         remain_r <= {HDR_LEN_W{1'b0}};
         err_r    <= ERR_NONE;
      end else begin
         state_r  <= state_s;
         addr_r   <= addr_s;
         remain_r <= remain_s;
         err_r    <= err_s;
         if (hdr_load_s) begin
            hdr_r <= data_in[HDR_BITS-1:0];
         end
      end
   end

endmodule
